// File: rtl/stall_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush controller: stall vectors, stage bits, FSM states.
// Also holds the reset polarity used across the controller and its counters.
package stall_ctrl_pkg;

  localparam int STALL_W = 6;

  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_LU   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_MC   = 6'b001111;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  localparam logic RST_ENABLE = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; one cycle from inc to q.
// Holds at all-ones; clear has priority over inc.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clear) begin
      q_d = '0;
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller: load-use stall plus a multi-cycle EX sequencer.
// Stall/flush/ready are combinational from state and inputs; stall count lags by one cycle.
module stall_ctrl #(
  parameter int MC_LEN_W = 6,
  parameter int CNT_W    = 32
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                stallreq_id_i,
  input  logic                mc_req_i,
  input  logic [MC_LEN_W-1:0] mc_len_i,
  input  logic                flush_i,
  output logic [5:0]          stall_o,
  output logic                flush_o,
  output logic                mc_ready_o,
  output logic                busy_o,
  output logic [CNT_W-1:0]    stall_cnt_o
);
  import stall_ctrl_pkg::*;

  localparam logic [MC_LEN_W-1:0] ONE = {{(MC_LEN_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [MC_LEN_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]    stall_cnt_q;
  logic                rst;

  assign rst = (Rst_n == RST_ENABLE);

  always_ff @(posedge Clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mc_req_i) begin
            state_d = BUSY;
            // A zero length still needs one BUSY cycle to deliver the ready pulse.
            cnt_d   = (mc_len_i == '0) ? ONE : mc_len_i;
          end
        end
        BUSY: begin
          if (cnt_q > ONE) begin
            cnt_d = cnt_q - ONE;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    stall_o    = STALL_NONE;
    flush_o    = 1'b0;
    mc_ready_o = 1'b0;
    busy_o     = 1'b0;
    if (!rst) begin
      busy_o = (state_q == BUSY);
      if (flush_i) begin
        flush_o = 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (mc_req_i) begin
              stall_o = STALL_MC;
            end else if (stallreq_id_i) begin
              stall_o = STALL_LU;
            end
          end
          BUSY: begin
            if (cnt_q > ONE) begin
              stall_o = STALL_MC;
            end else begin
              mc_ready_o = 1'b1;
              stall_o    = stallreq_id_i ? STALL_LU : STALL_NONE;
            end
          end
          default: stall_o = STALL_NONE;
        endcase
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (Clk),
    .inc   (stall_o[STG_PC]),
    .clear (rst),
    .q     (stall_cnt_q)
  );

  assign stall_cnt_o = rst ? '0 : stall_cnt_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl: expected outputs queued per step, compared mid-cycle.
// A second instance with a 4-bit counter exercises counter saturation.
module tb_stall_ctrl;

  logic        Clk;
  logic        Rst_n;
  logic        stallreq_id_i;
  logic        mc_req_i;
  logic [5:0]  mc_len_i;
  logic        flush_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic        mc_ready_o;
  logic        busy_o;
  logic [31:0] stall_cnt_o;
  logic [5:0]  stall4_o;
  logic        flush4_o;
  logic        mc_ready4_o;
  logic        busy4_o;
  logic [3:0]  stall_cnt4_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [5:0]  stall;
    logic        flush;
    logic        ready;
    logic        busy;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] cnt_m  = '0;
  logic [3:0]  cnt4_m = '0;

  stall_ctrl #(.MC_LEN_W(6), .CNT_W(32)) dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .stallreq_id_i (stallreq_id_i),
    .mc_req_i      (mc_req_i),
    .mc_len_i      (mc_len_i),
    .flush_i       (flush_i),
    .stall_o       (stall_o),
    .flush_o       (flush_o),
    .mc_ready_o    (mc_ready_o),
    .busy_o        (busy_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  stall_ctrl #(.MC_LEN_W(6), .CNT_W(4)) dut4 (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .stallreq_id_i (stallreq_id_i),
    .mc_req_i      (mc_req_i),
    .mc_len_i      (mc_len_i),
    .flush_i       (flush_i),
    .stall_o       (stall4_o),
    .flush_o       (flush4_o),
    .mc_ready_o    (mc_ready4_o),
    .busy_o        (busy4_o),
    .stall_cnt_o   (stall_cnt4_o)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs, compare at the falling edge.
  task automatic step(input string tag, input logic rst, input logic lu, input logic mc,
                      input logic [5:0] len, input logic fl, input logic [5:0] e_stall,
                      input logic e_flush, input logic e_ready, input logic e_busy);
    exp_t e;
    exp_t g;
    Rst_n         = rst;
    stallreq_id_i = lu;
    mc_req_i      = mc;
    mc_len_i      = len;
    flush_i       = fl;
    e.tag   = tag;
    e.stall = e_stall;
    e.flush = e_flush;
    e.ready = e_ready;
    e.busy  = e_busy;
    e.cnt   = rst ? 32'd0 : cnt_m;
    e.cnt4  = rst ? 4'd0 : cnt4_m;
    sb.push_back(e);
    @(negedge Clk);
    g = sb.pop_front();
    chk({g.tag, ".stall"}, {26'd0, stall_o}, {26'd0, g.stall});
    chk({g.tag, ".flush"}, {31'd0, flush_o}, {31'd0, g.flush});
    chk({g.tag, ".ready"}, {31'd0, mc_ready_o}, {31'd0, g.ready});
    chk({g.tag, ".busy"}, {31'd0, busy_o}, {31'd0, g.busy});
    chk({g.tag, ".cnt"}, stall_cnt_o, g.cnt);
    chk({g.tag, ".cnt4"}, {28'd0, stall_cnt4_o}, {28'd0, g.cnt4});
    if (rst) begin
      cnt_m  = '0;
      cnt4_m = '0;
    end else if (e_stall[0]) begin
      cnt_m  = cnt_m + 32'd1;
      if (cnt4_m != 4'hF) cnt4_m = cnt4_m + 4'd1;
    end
    @(posedge Clk);
    #1;
  endtask

  localparam logic [5:0] S0 = 6'b000000;
  localparam logic [5:0] LU = 6'b000111;
  localparam logic [5:0] MC = 6'b001111;

  initial begin
    Rst_n = 1'b1; stallreq_id_i = 1'b0; mc_req_i = 1'b0; mc_len_i = '0; flush_i = 1'b0;
    @(posedge Clk);
    #1;
    //    tag          rst lu  mc  len fl  stall flush ready busy
    step("rst_a",     1, 1, 1, 6'd3, 1, S0, 0, 0, 0);
    step("rst_b",     1, 1, 1, 6'd5, 0, S0, 0, 0, 0);
    // Reset arriving mid-BUSY
    step("rmb_c1",    0, 0, 1, 6'd5, 0, MC, 0, 0, 0);
    step("rmb_c2",    0, 0, 1, 6'd5, 0, MC, 0, 0, 1);
    step("rmb_c3",    1, 0, 1, 6'd5, 0, S0, 0, 0, 0);
    step("rmb_after", 0, 0, 0, 6'd0, 0, S0, 0, 0, 0);
    // Load-use only
    step("lu_c1",     0, 1, 0, 6'd0, 0, LU, 0, 0, 0);
    step("lu_c2",     0, 1, 0, 6'd0, 0, LU, 0, 0, 0);
    step("lu_after",  0, 0, 0, 6'd0, 0, S0, 0, 0, 0);
    // Multi-cycle length 3
    step("mc3_c1",    0, 0, 1, 6'd3, 0, MC, 0, 0, 0);
    step("mc3_c2",    0, 0, 1, 6'd3, 0, MC, 0, 0, 1);
    step("mc3_c3",    0, 0, 1, 6'd3, 0, MC, 0, 0, 1);
    step("mc3_rdy",   0, 0, 1, 6'd3, 0, S0, 0, 1, 1);
    step("mc3_idle",  0, 0, 0, 6'd0, 0, S0, 0, 0, 0);
    // Zero length then back-to-back length 2
    step("z_c1",      0, 0, 1, 6'd0, 0, MC, 0, 0, 0);
    step("z_rdy",     0, 0, 1, 6'd0, 0, S0, 0, 1, 1);
    step("b2b_c3",    0, 0, 1, 6'd2, 0, MC, 0, 0, 0);
    step("b2b_c4",    0, 0, 1, 6'd2, 0, MC, 0, 0, 1);
    step("b2b_rdy",   0, 0, 1, 6'd2, 0, S0, 0, 1, 1);
    step("b2b_idle",  0, 0, 0, 6'd0, 0, S0, 0, 0, 0);
    // Flush during BUSY discards the op
    step("fb_c1",     0, 0, 1, 6'd4, 0, MC, 0, 0, 0);
    step("fb_c2",     0, 0, 1, 6'd4, 0, MC, 0, 0, 1);
    step("fb_flush",  0, 1, 1, 6'd4, 1, S0, 1, 0, 1);
    step("fb_after",  0, 0, 0, 6'd4, 0, S0, 0, 0, 0);
    step("fb_after2", 0, 0, 0, 6'd4, 0, S0, 0, 0, 0);
    // Flush in the ready cycle
    step("fr_c1",     0, 0, 1, 6'd1, 0, MC, 0, 0, 0);
    step("fr_flush",  0, 0, 1, 6'd1, 1, S0, 1, 0, 1);
    step("fr_after",  0, 0, 0, 6'd0, 0, S0, 0, 0, 0);
    // Ready cycle with load-use
    step("rl_c1",     0, 0, 1, 6'd1, 0, MC, 0, 0, 0);
    step("rl_rdy",    0, 1, 1, 6'd1, 0, LU, 0, 1, 1);
    step("rl_after",  0, 0, 0, 6'd0, 0, S0, 0, 0, 0);
    // Flush in IDLE beats a new multi-cycle request
    step("fi_flush",  0, 1, 1, 6'd3, 1, S0, 1, 0, 0);
    step("fi_after",  0, 0, 0, 6'd3, 0, S0, 0, 0, 0);
    // Long load-use run drives the 4-bit counter into saturation
    for (int i = 0; i < 20; i++) begin
      step("sat_lu",  0, 1, 0, 6'd0, 0, LU, 0, 0, 0);
    end
    step("sat_end",   0, 0, 0, 6'd0, 0, S0, 0, 0, 0);
    chk("sat_cnt4_final", {28'd0, stall_cnt4_o}, 32'h0000000F);
    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

Pipeline stall/flush controller for the five-stage core. It combines the decode-stage load-use stall request with a counter-driven sequencer that holds the pipeline while the execute stage runs a multi-cycle operation. It drives a 6-bit per-stage stall vector and a flush strobe to all pipeline registers. It also keeps a saturating stall-cycle counter for performance monitoring.

## Interface
- MC_LEN_W, 6: width of the multi-cycle length field.
- CNT_W, 32: width of the stall-cycle counter.

Ports:
- Clk  in  1  core clock; single clock domain. One clock; reset is synchronous and active-high.
- Rst_n  in  1  synchronous reset, active-high (asserted = `RstEnable` = 1'b1).
- stallreq_id_i  in  1  load-use hazard from decode; combinational, same cycle.
- mc_req_i  in  1  execute stage holds a multi-cycle op; held high while the op is in EX.
- mc_len_i  in  MC_LEN_W  extra EX cycles needed; sampled with mc_req_i.
- flush_i  in  1  exception/redirect; aborts everything.
- stall_o  out  6  per-stage hold: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb.
- flush_o  out  1  clear all pipeline registers this cycle.
- mc_ready_o  out  1  EX result valid; EX writes it this cycle.
- busy_o  out  1  sequencer not IDLE.
- stall_cnt_o  out  CNT_W  cycles with stall_o[0]=1, saturating.

## Operation
- States: IDLE, BUSY. Registers: state, cnt[MC_LEN_W-1:0], stall_cnt.
- Stall encodings:
  - STALL_NONE = 6'b000000.
  - STALL_LU = 6'b000111: hold pc/if/id, bubble into EX.
  - STALL_MC = 6'b001111: hold pc..ex, bubble into MEM.
- IDLE, mc_req_i=1 (no flush):
  - stall_o=STALL_MC.
  - cnt <= max(mc_len_i,1); mc_len_i=0 is treated as 1.
  - next state BUSY.
- IDLE, mc_req_i=0: stall_o = stallreq_id_i ? STALL_LU : STALL_NONE.
- BUSY, cnt>1: stall_o=STALL_MC; cnt decrements; mc_req_i and mc_len_i are ignored.
- BUSY, cnt==1:
  - mc_ready_o=1.
  - stall_o = stallreq_id_i ? STALL_LU : STALL_NONE.
  - next state IDLE.
- Priority: flush_i > STALL_MC > STALL_LU.
- flush_i=1 in any state:
  - stall_o=STALL_NONE, flush_o=1, mc_ready_o=0.
  - next state IDLE, cnt <= 0.
  - An in-flight multi-cycle op is discarded with no ready pulse.
- stall_cnt increments in every cycle where stall_o[0]=1, and holds at all-ones.
- busy_o = (state==BUSY).

## Timing
- stall_o, flush_o and mc_ready_o are combinational from state, cnt and the current inputs; there are no registered outputs on this path.
- The load-use stall takes effect in the same cycle stallreq_id_i is asserted.
- A multi-cycle op occupies EX for max(mc_len_i,1)+1 cycles: one IDLE cycle, then mc_len_i BUSY cycles, the last of which is the ready cycle.
- Back-to-back multi-cycle ops: the second op's mc_req_i is first sampled in the IDLE cycle after the ready cycle. There is no idle gap beyond that cycle.
- stall_cnt_o is registered and lags stall_o by one cycle.
- Reset (Rst_n=1 at a Clk edge), including mid-BUSY:
  - state IDLE, cnt 0, stall_cnt 0.
  - While reset is asserted, all outputs are 0 regardless of inputs.
- Flush in the ready cycle: the flush wins and mc_ready_o=0.

## Structure
- define.v holds:
  - STALL_NONE, STALL_LU, STALL_MC.
  - Stage-bit indices.
  - State encodings: IDLE=1'b0, BUSY=1'b1.
  - RstEnable.
- Sub-module sat_counter (parameter W; inputs inc and clear; output q) implements stall_cnt. The same module is reused for the other performance counters.

## Test plan
- Reset mid-BUSY: mc_req_i=1, mc_len_i=5, assert Rst_n on the 3rd cycle -> next cycle stall_o=0, busy_o=0, stall_cnt_o=0.
- Load-use only: stallreq_id_i=1 for 2 cycles -> stall_o=6'b000111 in both cycles; stall_cnt_o=2 afterwards.
- Multi-cycle: mc_req_i=1 held, mc_len_i=3 -> stall_o=6'b001111 for 3 cycles, then a 4th cycle with stall_o=0 and mc_ready_o=1; busy_o high for cycles 2-4.
- Zero length plus back-to-back: first op mc_len_i=0 -> STALL_MC for 1 cycle, ready in cycle 2. Next op mc_len_i=2 in cycle 3 -> ready in cycle 5.
- Flush during BUSY: mc_len_i=4, flush_i=1 in cycle 3 -> flush_o=1, stall_o=0 that cycle; no mc_ready_o pulse; IDLE next cycle.
- Ready plus load-use: stallreq_id_i=1 in the ready cycle -> mc_ready_o=1 and stall_o=6'b000111. Saturation: preload the counter at all-ones via a reduced-CNT_W build (CNT_W=4) -> holds at 4'hF.
